// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one combinational comparator between the ID-stage
// branch unit (port 0) and the EX-stage set/compare unit (port 1).
// Each transaction takes IDLE -> ISSUE -> RESP; the comparator result is
// captured at the end of ISSUE and held until the owner takes it.
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // port 0: ID-stage branch
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [3:0]       req_op_0,
  input  logic             req_usigned_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_data_0,
  // port 1: EX-stage set/compare
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_op_1,
  input  logic             req_usigned_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_data_1,
  // shared comparator
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [3:0]       cmp_op,
  output logic             cmp_usigned,
  input  logic [WIDTH-1:0] cmp_c,
  // control / status
  input  logic             flush,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       op_q;
  logic             us_q;

  logic [1:0]       vld, gnt;
  logic             acc0, acc1, kill, done;

  // round-robin pick: lone requester wins, a tie goes to the port not granted last
  always_comb begin
    vld = {req_valid_1, req_valid_0};
    gnt = vld;
    if (vld == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  // rst_n gates ready so nothing looks acceptable while reset is held
  assign req_ready_0 = rst_n && (state == IDLE) && gnt[0] && !flush;
  assign req_ready_1 = rst_n && (state == IDLE) && gnt[1];
  assign acc0        = req_valid_0 && req_ready_0;
  assign acc1        = req_valid_1 && req_ready_1;

  // a flush only kills work owned by the branch port
  assign kill        = flush && !owner && (state != IDLE);

  // flush suppresses port-0 response in the very cycle it arrives
  assign rsp_valid_0 = (state == RESP) && !owner && !flush;
  assign rsp_valid_1 = (state == RESP) && owner;
  assign done        = (rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1);
  assign rsp_data_0  = rsp_valid_0 ? res_q : '0;
  assign rsp_data_1  = rsp_valid_1 ? res_q : '0;

  // comparator always sees the operand registers; only ISSUE matters to it
  assign cmp_a       = a_q;
  assign cmp_b       = b_q;
  assign cmp_op      = op_q;
  assign cmp_usigned = us_q;
  assign busy        = (state != IDLE);

  // transaction FSM with operand/result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      us_q       <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0) begin
            a_q        <= req_a_0;
            b_q        <= req_b_0;
            op_q       <= req_op_0;
            us_q       <= req_usigned_0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= ISSUE;
          end else if (acc1) begin
            a_q        <= req_a_1;
            b_q        <= req_b_1;
            op_q       <= req_op_1;
            us_q       <= req_usigned_1;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (kill) state <= IDLE;
          else begin
            res_q <= cmp_c;
            state <= RESP;
          end
        end
        RESP: begin
          if (kill || done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have, per requester i in {0 = ID-stage branch, 1 = EX-stage set/compare}, ports req_valid_i (in, 1), req_ready_i (out, 1), req_a_i (in, WIDTH), req_b_i (in, WIDTH), req_op_i (in, 4) and req_usigned_i (in, 1).
REQ-005 The block SHALL have, per requester i, ports rsp_valid_i (out, 1), rsp_ready_i (in, 1) and rsp_data_i (out, WIDTH).
REQ-006 The block SHALL have comparator-side ports cmp_a (out, WIDTH), cmp_b (out, WIDTH), cmp_op (out, 4), cmp_usigned (out, 1) and cmp_c (in, WIDTH), where cmp_c is the shared comparator's combinational result.
REQ-007 The block SHALL have port flush, input, 1, which kills any port-0 transaction.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP; the owner register (1 bit) SHALL record the granted port.
REQ-010 Arbitration SHALL be round-robin: a port requesting alone wins; if both request, the port not in last_grant wins; last_grant SHALL update on each accept.
REQ-011 req_ready_i SHALL be combinational and equal (state==IDLE) && grant==i && !(flush && i==0); at most one req_ready SHALL be high per cycle.
REQ-012 An accept (req_valid_i && req_ready_i) SHALL latch a, b, op and usigned into operand registers, set owner=i and move IDLE->ISSUE.
REQ-013 In ISSUE, cmp_* SHALL be driven from the operand registers; cmp_c SHALL be captured into a result register at the clock edge, and the FSM SHALL move ISSUE->RESP.
REQ-014 In IDLE and RESP, cmp_* SHALL hold the operand registers' last values; they are don't-care to the comparator.
REQ-015 In RESP, rsp_valid_owner SHALL be 1 and rsp_data_owner SHALL equal the result register; the other port's rsp_valid SHALL be 0.
REQ-016 RESP->IDLE SHALL occur on rsp_valid && rsp_ready; rsp_data SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-017 Latency SHALL be: accept at cycle N, ISSUE at N+1, rsp_valid at N+2; minimum throughput is one transaction per 3 cycles, with no accept in the RESP->IDLE cycle.
REQ-018 rsp_data_i SHALL read 0 whenever rsp_valid_i is 0.
REQ-019 Operand and op values SHALL pass through unmodified; the block SHALL NOT interpret op or usigned.
REQ-020 flush, when the FSM is in ISSUE or RESP with owner=0, SHALL force the next state to IDLE with no rsp_valid_0 that cycle or after; last_grant SHALL be unchanged.
REQ-021 flush with owner=1 or in IDLE SHALL NOT affect port 1; in IDLE it SHALL only block port-0 accept per REQ-011.
REQ-022 Holding req_valid without ready SHALL NOT change state; requesters SHALL hold their operands stable until accept.

Reset
REQ-023 While rst_n=0: state=IDLE, owner=0, last_grant=1 (port 0 wins the first tie), operand and result registers 0, all rsp_valid 0, busy 0, all req_ready 0.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately and asynchronously; no response for it SHALL appear after release.
REQ-025 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-026 Single: port0 a=5, b=5, op=EQ, cmp model gives 1 -> rsp_valid_0 at N+2, rsp_data_0=1, busy high for N+1..N+2.
REQ-027 Tie: both valid after reset -> port0 accepted first, then port1; under continuous requests, grants alternate 0,1,0,1.
REQ-028 Backpressure: rsp_ready_1=0 for 5 cycles -> rsp_valid_1 and rsp_data_1 (0xFFFFFFFF) held constant, req_ready_0 stays 0 until handshake.
REQ-029 Flush: port0 accepted, flush in ISSUE -> no rsp_valid_0, IDLE next cycle, pending port1 accepted the following cycle.
REQ-030 Reset: rst_n low during RESP -> rsp_valid drops without a clock edge; after release all outputs at reset values and no stale response.
REQ-031 Signed/unsigned: a=0xFFFFFFFF, b=1, usigned=0 then 1 -> cmp_usigned observed 0 then 1 in the respective ISSUE cycles.
